// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the PC through program memory, follows taken branches, stops on HALT_WORD.
// Latency: pc/state update one clock after the retiring instruction; mcode is combinational from instr_in.
// Backpressure: none; every RUN cycle retires exactly one instruction, start is only honoured in IDLE/HALT.
module fetch_unit #(
    parameter int              IW        = 9,
    parameter int              PCW       = 10,
    parameter int              mcodebits = 3,
    parameter logic [IW-1:0]   HALT_WORD = {IW{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IW-1:0]        instr_in,
    input  logic                 branch,
    input  logic                 taken,
    input  logic [PCW-1:0]       target,
    output logic [PCW-1:0]       pc,
    output logic [mcodebits-1:0] mcode,
    output logic                 fetch_valid,
    output logic                 done,
    output logic [15:0]          instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [15:0]    count_q, count_d;

    logic           is_halt;
    logic           branch_taken;
    logic [15:0]    count_inc;

    assign is_halt      = (instr_in == HALT_WORD);
    assign branch_taken = branch && taken;
    // Retire counter sticks at all-ones so long runs never read as short ones.
    assign count_inc    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (is_halt) state_d = HALT;
            HALT:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // PC and retire-count datapath
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) count_d = '0;
            end
            RUN: begin
                count_d = count_inc;
                if (is_halt)
                    pc_d = pc_q;
                else if (branch_taken)
                    pc_d = target;
                else
                    pc_d = pc_q + PCW'(1);
            end
            HALT: begin
                if (start) begin
                    pc_d    = '0;
                    count_d = '0;
                end
            end
            default: begin
                pc_d    = '0;
                count_d = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        fetch_valid = 1'b0;
        done        = 1'b0;
        case (state_q)
            RUN:     fetch_valid = 1'b1;
            HALT:    done        = 1'b1;
            default: begin
                fetch_valid = 1'b0;
                done        = 1'b0;
            end
        endcase
    end

    assign pc          = pc_q;
    assign instr_count = count_q;
    assign mcode       = instr_in[IW-1:IW-mcodebits];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives one scenario and checks against hand-computed values.
module tb_fetch_unit;

    localparam int            IW   = 9;
    localparam int            PCW  = 10;
    localparam int            MCB  = 3;
    localparam logic [IW-1:0] HW   = {IW{1'b1}};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [IW-1:0]   instr_in = 9'h012;
    logic            branch = 1'b0;
    logic            taken = 1'b0;
    logic [PCW-1:0]  target = '0;
    logic [PCW-1:0]  pc;
    logic [MCB-1:0]  mcode;
    logic            fetch_valid;
    logic            done;
    logic [15:0]     instr_count;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.IW(IW), .PCW(PCW), .mcodebits(MCB), .HALT_WORD(HW)) dut (
        .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
        .branch(branch), .taken(taken), .target(target), .pc(pc),
        .mcode(mcode), .fetch_valid(fetch_valid), .done(done),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; branch = 1'b1; taken = 1'b1; target = 10'd33;
        tick();
        checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", instr_count); end
        reset = 1'b0; start = 1'b0; instr_in = HW;
        repeat (3) tick();
        checks++; if (fetch_valid !== 1'b0 || done !== 1'b0 || pc !== 10'd0) begin
            errors++; $display("FAIL idle_hold fv=%b done=%b pc=%0d exp fv=0 done=0 pc=0", fetch_valid, done, pc);
        end
        branch = 1'b0; taken = 1'b0; target = '0;
    endtask

    task automatic test_mcode();
        instr_in = 9'b101_010101;
        #1;
        checks++; if (mcode !== 3'b101) begin errors++; $display("FAIL mcode_idle got=%b exp=101", mcode); end
        instr_in = 9'b011_111000;
        #1;
        checks++; if (mcode !== 3'b011) begin errors++; $display("FAIL mcode_idle2 got=%b exp=011", mcode); end
    endtask

    task automatic test_straight_line();
        instr_in = 9'h012;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || pc !== 10'd0 || instr_count !== 16'd0) begin
            errors++; $display("FAIL start_run fv=%b pc=%0d cnt=%0d exp fv=1 pc=0 cnt=0", fetch_valid, pc, instr_count);
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (pc !== PCW'(i)) begin errors++; $display("FAIL line_pc got=%0d exp=%0d", pc, i); end
            instr_in = (i == 5) ? HW : IW'(9'h020 + i);
            tick();
        end
        checks++; if (done !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL line_halt done=%b fv=%b exp done=1 fv=0", done, fetch_valid);
        end
        checks++; if (pc !== 10'd5) begin errors++; $display("FAIL line_halt_pc got=%0d exp=5", pc); end
        checks++; if (instr_count !== 16'd6) begin errors++; $display("FAIL line_cnt got=%0d exp=6", instr_count); end
        instr_in = 9'h012; branch = 1'b1; taken = 1'b1; target = 10'd99;
        repeat (3) tick();
        checks++; if (pc !== 10'd5 || instr_count !== 16'd6 || done !== 1'b1) begin
            errors++; $display("FAIL halt_frozen pc=%0d cnt=%0d done=%b exp pc=5 cnt=6 done=1", pc, instr_count, done);
        end
        branch = 1'b0; taken = 1'b0; target = '0;
    endtask

    task automatic test_restart();
        instr_in = 9'h012;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (fetch_valid !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL restart_state fv=%b done=%b exp fv=1 done=0", fetch_valid, done);
        end
        checks++; if (pc !== 10'd0 || instr_count !== 16'd0) begin
            errors++; $display("FAIL restart_clr pc=%0d cnt=%0d exp pc=0 cnt=0", pc, instr_count);
        end
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (pc !== 10'd3 || instr_count !== 16'd3 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL start_in_run pc=%0d cnt=%0d fv=%b exp pc=3 cnt=3 fv=1", pc, instr_count, fetch_valid);
        end
    endtask

    task automatic test_branch();
        branch = 1'b1; taken = 1'b1; target = 10'd2;
        tick();
        checks++; if (pc !== 10'd2 || instr_count !== 16'd4) begin
            errors++; $display("FAIL br_to2 pc=%0d cnt=%0d exp pc=2 cnt=4", pc, instr_count);
        end
        target = 10'd40;
        tick();
        checks++; if (pc !== 10'd40) begin errors++; $display("FAIL br_taken got=%0d exp=40", pc); end
        target = 10'd2;
        tick();
        taken = 1'b0; target = 10'd40;
        tick();
        checks++; if (pc !== 10'd3) begin errors++; $display("FAIL br_not_taken got=%0d exp=3", pc); end
        taken = 1'b1; target = 10'd2;
        tick();
        branch = 1'b0; target = 10'd40;
        tick();
        checks++; if (pc !== 10'd3 || instr_count !== 16'd9) begin
            errors++; $display("FAIL br_no_branch pc=%0d cnt=%0d exp pc=3 cnt=9", pc, instr_count);
        end
        taken = 1'b0;
    endtask

    task automatic test_wrap();
        branch = 1'b1; taken = 1'b1; target = 10'd1023;
        tick();
        checks++; if (pc !== 10'd1023) begin errors++; $display("FAIL wrap_setup got=%0d exp=1023", pc); end
        branch = 1'b0; taken = 1'b0;
        tick();
        checks++; if (pc !== 10'd0 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL wrap pc=%0d fv=%b exp pc=0 fv=1", pc, fetch_valid);
        end
    endtask

    task automatic test_halt_priority();
        branch = 1'b1; taken = 1'b1; target = 10'd9;
        tick();
        instr_in = HW; target = 10'd7;
        tick();
        checks++; if (done !== 1'b1 || pc !== 10'd9) begin
            errors++; $display("FAIL halt_prio done=%b pc=%0d exp done=1 pc=9", done, pc);
        end
        tick();
        checks++; if (pc !== 10'd9) begin errors++; $display("FAIL halt_ignore_br got=%0d exp=9", pc); end
        instr_in = 9'h012; branch = 1'b0; taken = 1'b0;
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        tick();
        start = 1'b0;
        branch = 1'b1; taken = 1'b1; target = 10'd17;
        tick();
        checks++; if (pc !== 10'd17) begin errors++; $display("FAIL rst_setup got=%0d exp=17", pc); end
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        checks++; if (pc !== 10'd0 || instr_count !== 16'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_midrun pc=%0d cnt=%0d fv=%b done=%b exp 0 0 0 0", pc, instr_count, fetch_valid, done);
        end
        instr_in = HW;
        repeat (3) tick();
        checks++; if (pc !== 10'd0 || fetch_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_stay_idle pc=%0d fv=%b done=%b exp 0 0 0", pc, fetch_valid, done);
        end
        // Enter HALT, then reset with start held: must land in IDLE, not RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        checks++; if (done !== 1'b0 || fetch_valid !== 1'b0 || instr_count !== 16'd0) begin
            errors++; $display("FAIL rst_in_halt done=%b fv=%b cnt=%0d exp 0 0 0", done, fetch_valid, instr_count);
        end
        instr_in = 9'h012; branch = 1'b0; taken = 1'b0;
    endtask

    task automatic test_saturation();
        start = 1'b1;
        tick();
        start = 1'b0;
        branch = 1'b1; taken = 1'b1; target = 10'd5;
        tick();
        repeat (65533) tick();
        checks++; if (instr_count !== 16'hFFFE || pc !== 10'd5) begin
            errors++; $display("FAIL sat_pre cnt=%h pc=%0d exp cnt=fffe pc=5", instr_count, pc);
        end
        tick();
        checks++; if (instr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got=%h exp=ffff", instr_count); end
        repeat (4400) tick();
        checks++; if (instr_count !== 16'hFFFF || pc !== 10'd5 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL sat_hold cnt=%h pc=%0d fv=%b exp ffff 5 1", instr_count, pc, fetch_valid);
        end
        branch = 1'b0; taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mcode();
        test_straight_line();
        test_restart();
        test_branch();
        test_wrap();
        test_halt_priority();
        test_reset_midrun();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
